// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Central sequencing controller for the 5-stage pipeline. It inserts a bubble
// on a load-use hazard, flushes IF/ID on a taken branch or jump resolved in ID,
// freezes the pipeline while a data-memory access waits for its acknowledge,
// and moves to a sticky error state when the wait exceeds MEM_TIMEOUT cycles.
// It also keeps a saturating count of stall cycles.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  CPU start, only looked at in IDLE
//   IF_ID_RsAddr_i/RtAddr_i  source registers of the instruction in ID
//   ID_EX_MemRead_i/RtAddr_i load in EX and its destination register
//   ID_BranchTaken_i         branch in ID resolved taken
//   ID_Jump_i                jump in ID
//   EX_MEM_MemAccess_i       instruction in MEM accesses data memory
//   DMem_Ack_i               data memory completes the access this cycle
//   PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, Pipe_Freeze_o,
//   MemReq_o                 combinational pipeline controls
//   MemTimeout_o             registered sticky timeout flag
//   StallCount_o             registered saturating stall-cycle counter
module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned WAIT_W      = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IF_ID_RsAddr_i,
    input  logic [4:0]       IF_ID_RtAddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RtAddr_i,
    input  logic             ID_BranchTaken_i,
    input  logic             ID_Jump_i,
    input  logic             EX_MEM_MemAccess_i,
    input  logic             DMem_Ack_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             Pipe_Freeze_o,
    output logic             MemReq_o,
    output logic             MemTimeout_o,
    output logic [CNT_W-1:0] StallCount_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_e;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic memwait;
    logic loaduse;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_req;

    // Hazard detection, evaluated every cycle but only acted on in RUN/MEM_WAIT
    assign memwait = EX_MEM_MemAccess_i & ~DMem_Ack_i;
    assign loaduse = ID_EX_MemRead_i & (ID_EX_RtAddr_i != 5'd0) &
                     ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) |
                      (ID_EX_RtAddr_i == IF_ID_RtAddr_i));

    // State register and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and pipeline control outputs
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b1;
        mem_req     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end

            S_RUN, S_MEM_WAIT: begin
                mem_req = EX_MEM_MemAccess_i;
                // memwait > loaduse > branch/jump; a branch seen together with
                // a load-use hazard is resolved again next cycle, so no flush.
                if (memwait) begin
                    pipe_freeze = 1'b1;
                end else if (loaduse) begin
                    pipe_freeze = 1'b0;
                    idex_bubble = 1'b1;
                end else begin
                    pipe_freeze = 1'b0;
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = ID_BranchTaken_i | ID_Jump_i;
                end

                if (state_q == S_RUN) begin
                    if (memwait) begin
                        state_d = S_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end
                end else begin
                    if (DMem_Ack_i) begin
                        state_d = S_RUN;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating stall counter: counts active-state cycles with the PC held
    always_comb begin
        cnt_d = cnt_q;
        if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_write &&
            (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign PC_Write_o     = pc_write;
    assign IF_ID_Write_o  = ifid_write;
    assign IF_ID_Flush_o  = ifid_flush;
    assign ID_EX_Bubble_o = idex_bubble;
    assign Pipe_Freeze_o  = pipe_freeze;
    assign MemReq_o       = mem_req;
    assign MemTimeout_o   = timeout_q;
    assign StallCount_o   = cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: a table of per-cycle
// input/expected-output records plus hand-written timeout-boundary sequences.
// Registered results are queued when a vector is driven and compared after
// the clock edge.
module tb_hazard_stall_controller;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [4:0]          IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_EX_RtAddr_i;
    logic                ID_EX_MemRead_i, ID_BranchTaken_i, ID_Jump_i;
    logic                EX_MEM_MemAccess_i, DMem_Ack_i;
    logic                PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o;
    logic                ID_EX_Bubble_o, Pipe_Freeze_o, MemReq_o, MemTimeout_o;
    logic [TB_CNT_W-1:0] StallCount_o;

    hazard_stall_controller #(
        .MEM_TIMEOUT(4),
        .WAIT_W     (8),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .IF_ID_RsAddr_i    (IF_ID_RsAddr_i),
        .IF_ID_RtAddr_i    (IF_ID_RtAddr_i),
        .ID_EX_MemRead_i   (ID_EX_MemRead_i),
        .ID_EX_RtAddr_i    (ID_EX_RtAddr_i),
        .ID_BranchTaken_i  (ID_BranchTaken_i),
        .ID_Jump_i         (ID_Jump_i),
        .EX_MEM_MemAccess_i(EX_MEM_MemAccess_i),
        .DMem_Ack_i        (DMem_Ack_i),
        .PC_Write_o        (PC_Write_o),
        .IF_ID_Write_o     (IF_ID_Write_o),
        .IF_ID_Flush_o     (IF_ID_Flush_o),
        .ID_EX_Bubble_o    (ID_EX_Bubble_o),
        .Pipe_Freeze_o     (Pipe_Freeze_o),
        .MemReq_o          (MemReq_o),
        .MemTimeout_o      (MemTimeout_o),
        .StallCount_o      (StallCount_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected combinational outputs packed as {pc, ifw, flush, bubble, freeze, req}
    localparam logic [5:0] O_IDLE  = 6'b000010;
    localparam logic [5:0] O_NORM  = 6'b110000;
    localparam logic [5:0] O_NORMQ = 6'b110001;
    localparam logic [5:0] O_BUB   = 6'b000100;
    localparam logic [5:0] O_BUBQ  = 6'b000101;
    localparam logic [5:0] O_FLUSH = 6'b111000;
    localparam logic [5:0] O_FRZQ  = 6'b000011;

    typedef struct {
        logic       rst;
        logic       start;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ldrt;
        logic       br;
        logic       jmp;
        logic       acc;
        logic       ack;
        logic [5:0] exp_o;
        int         exp_cnt;
        logic       exp_to;
    } vec_t;

    typedef struct {
        int   cnt;
        logic to;
        int   idx;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic start,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic mr, input logic [4:0] ldrt,
                                input logic br, input logic jmp,
                                input logic acc, input logic ack,
                                input logic [5:0] o, input int cnt, input logic to);
        vec_t v;
        v.rst = rst; v.start = start; v.rs = rs; v.rt = rt; v.mr = mr;
        v.ldrt = ldrt; v.br = br; v.jmp = jmp; v.acc = acc; v.ack = ack;
        v.exp_o = o; v.exp_cnt = cnt; v.exp_to = to;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector for one cycle; check combinational outputs mid-cycle and
    // registered outputs just after the following rising edge.
    task automatic apply(input vec_t v, input int idx);
        sb_t e;
        @(negedge clk_i);
        rst_i = v.rst; start_i = v.start;
        IF_ID_RsAddr_i = v.rs; IF_ID_RtAddr_i = v.rt;
        ID_EX_MemRead_i = v.mr; ID_EX_RtAddr_i = v.ldrt;
        ID_BranchTaken_i = v.br; ID_Jump_i = v.jmp;
        EX_MEM_MemAccess_i = v.acc; DMem_Ack_i = v.ack;
        #1;
        chk($sformatf("v%0d PC_Write", idx),     int'(PC_Write_o),     int'(v.exp_o[5]));
        chk($sformatf("v%0d IF_ID_Write", idx),  int'(IF_ID_Write_o),  int'(v.exp_o[4]));
        chk($sformatf("v%0d IF_ID_Flush", idx),  int'(IF_ID_Flush_o),  int'(v.exp_o[3]));
        chk($sformatf("v%0d ID_EX_Bubble", idx), int'(ID_EX_Bubble_o), int'(v.exp_o[2]));
        chk($sformatf("v%0d Pipe_Freeze", idx),  int'(Pipe_Freeze_o),  int'(v.exp_o[1]));
        chk($sformatf("v%0d MemReq", idx),       int'(MemReq_o),       int'(v.exp_o[0]));
        e.cnt = v.exp_cnt; e.to = v.exp_to; e.idx = idx;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d StallCount", e.idx), int'(StallCount_o), e.cnt);
        chk($sformatf("v%0d MemTimeout", e.idx), int'(MemTimeout_o), int'(e.to));
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        IF_ID_RsAddr_i = '0; IF_ID_RtAddr_i = '0; ID_EX_RtAddr_i = '0;
        ID_EX_MemRead_i = 1'b0; ID_BranchTaken_i = 1'b0; ID_Jump_i = 1'b0;
        EX_MEM_MemAccess_i = 1'b0; DMem_Ack_i = 1'b0;

        // Basic run, load-use, branch/jump, memory wait with late ack
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0, O_IDLE,  0, 0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 1,0, O_IDLE,  0, 0));
        tbl.push_back(mk(0,0, 1,2, 0,0, 0,0, 0,0, O_NORM,  0, 0));
        tbl.push_back(mk(0,0, 5,2, 1,5, 0,0, 0,0, O_BUB,   1, 0));
        tbl.push_back(mk(0,0, 5,2, 0,5, 0,0, 0,0, O_NORM,  1, 0));
        tbl.push_back(mk(0,0, 0,0, 1,0, 0,0, 0,0, O_NORM,  1, 0));
        tbl.push_back(mk(0,0, 3,7, 1,7, 1,0, 0,0, O_BUB,   2, 0));
        tbl.push_back(mk(0,0, 3,7, 0,7, 1,0, 0,0, O_FLUSH, 2, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,1, 0,0, O_FLUSH, 2, 0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 0,0, O_NORM,  2, 0));
        tbl.push_back(mk(0,0, 3,4, 1,9, 0,0, 0,0, O_NORM,  2, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,1, O_NORMQ, 2, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  3, 0));
        tbl.push_back(mk(0,0, 5,0, 1,5, 1,0, 1,0, O_FRZQ,  4, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  5, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,1, O_NORMQ, 5, 0));
        tbl.push_back(mk(0,0, 6,0, 1,6, 0,0, 1,1, O_BUBQ,  6, 0));
        // Timeout: entry cycle, then four MEM_WAIT cycles without ack
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  7, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  8, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  9, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ, 10, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ, 11, 1));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 1,1, O_IDLE, 11, 1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0, O_IDLE, 11, 1));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, O_IDLE,  0, 0));
        // Saturation of the 4-bit stall counter under a held load-use hazard
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 0,0, O_IDLE,  0, 0));
        for (int k = 1; k <= 17; k++) begin
            tbl.push_back(mk(0,0, 5,0, 1,5, 0,0, 0,0, O_BUB, (k > 15) ? 15 : k, 0));
        end
        // Reset wins over a stall increment and over MEM_WAIT
        tbl.push_back(mk(1,0, 5,0, 1,5, 0,0, 0,0, O_BUB,   0, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_IDLE,  0, 0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 0,0, O_IDLE,  0, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  1, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  0, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_IDLE,  0, 0));

        // Reset sequence
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset StallCount", int'(StallCount_o), 0);
        chk("reset MemTimeout", int'(MemTimeout_o), 0);
        chk("reset PC_Write", int'(PC_Write_o), 0);
        chk("reset Pipe_Freeze", int'(Pipe_Freeze_o), 1);

        foreach (tbl[i]) apply(tbl[i], i);

        // Ack arriving in the very cycle the wait counter hits the limit
        apply(mk(0,1, 0,0, 0,0, 0,0, 0,0, O_IDLE,  0, 0), 100);
        apply(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  1, 0), 101);
        for (int k = 0; k < 3; k++) begin
            apply(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ, 2 + k, 0), 102 + k);
        end
        apply(mk(0,0, 0,0, 0,0, 0,0, 1,1, O_NORMQ, 4, 0), 105);
        apply(mk(0,0, 0,0, 0,0, 0,0, 0,0, O_NORM,  4, 0), 106);
        apply(mk(0,0, 0,0, 0,0, 0,0, 1,0, O_FRZQ,  5, 0), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
